// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths and the transfer state encoding.
package apb_pkg;

  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_initiator_if.sv
// Command, response and APB bus bundle for the APB initiator.
// master = initiator side, slave = the side that feeds commands and plays the APB responder.
interface apb_initiator_if #(
  parameter int ADDR_W = apb_pkg::APB_ADDR_W,
  parameter int DATA_W = apb_pkg::APB_DATA_W
) ();

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_write_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              rsp_timeout_o;

  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [ADDR_W-1:0] paddr_o;
  logic [DATA_W-1:0] pwdata_o;
  logic [DATA_W-1:0] prdata_i;
  logic              pready_i;
  logic              pslverr_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
    output cmd_ready_o,
    input  rsp_ready_i,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    input  prdata_i, pready_i, pslverr_i
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
    input  cmd_ready_o,
    output rsp_ready_i,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    output prdata_i, pready_i, pslverr_i
  );

endinterface

// File: rtl/apb_initiator.sv
// APB3 initiator: one command at a time, SETUP -> ACCESS with wait states and an optional
// ACCESS timeout; status and read data come back on a held valid/ready response.
module apb_initiator
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             pclk_i,
  input  logic             prst_i,
  apb_initiator_if.master  bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Count value seen on the last allowed low-pready ACCESS cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  apb_state_e        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              cmd_ready;

  assign cmd_ready = (state == IDLE) && !rsp_valid_q;

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      if (rsp_valid_q && bus.rsp_ready_i) rsp_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.cmd_valid_i && cmd_ready) begin
            if (bus.cmd_addr_i[1:0] == 2'b00) begin
              state    <= SETUP;
              psel_q   <= 1'b1;
              pwrite_q <= bus.cmd_write_i;
              paddr_q  <= bus.cmd_addr_i;
              pwdata_q <= bus.cmd_wdata_i;
            end else begin
              // Misaligned: answer with an error without touching the bus.
              rsp_valid_q   <= 1'b1;
              rsp_err_q     <= 1'b1;
              rsp_timeout_q <= 1'b0;
              rsp_rdata_q   <= '0;
            end
          end
        end

        SETUP: begin
          state     <= ACCESS;
          penable_q <= 1'b1;
          wait_cnt  <= '0;
        end

        ACCESS: begin
          if (bus.pready_i) begin
            state         <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= bus.pslverr_i;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata_i;
          end else if (TIMEOUT_CYCLES != 0 && wait_cnt == CNT_LAST) begin
            state         <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o   = cmd_ready;
  assign bus.psel_o        = psel_q;
  assign bus.penable_o     = penable_q;
  assign bus.pwrite_o      = pwrite_q;
  assign bus.paddr_o       = paddr_q;
  assign bus.pwdata_o      = pwdata_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.rsp_timeout_o = rsp_timeout_q;
  assign bus.rsp_rdata_o   = rsp_rdata_q;

endmodule
